// File: rtl/cp0_reg.sv
// cp0_reg: MIPS coprocessor-0 register file (Count, Compare, Status, Cause,
// EPC, BadVAddr, EBase) with timer interrupt, exception/eret commit and
// mtc0 write / mfc0 read ports.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   we_i, waddr_i, wsel_i,   mtc0 write (write-back stage)
//   data_i
//   raddr_i, rsel_i, data_o  mfc0 read, combinational, forwards a same-cycle write
//   int_i                    level-sensitive hardware interrupt lines -> Cause[15:10]
//   excepttype_i, current_inst_addr_i, is_in_delayslot_i, bad_addr_i
//                            committed exception from the memory stage (0 = none, 0x0e = eret)
//   count_o .. badvaddr_o    register contents
//   timer_int_o              timer interrupt request
module cp0_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [4:0]        waddr_i,
    input  logic [2:0]        wsel_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [4:0]        raddr_i,
    input  logic [2:0]        rsel_i,
    input  logic [5:0]        int_i,
    input  logic [DATA_W-1:0] excepttype_i,
    input  logic [DATA_W-1:0] current_inst_addr_i,
    input  logic              is_in_delayslot_i,
    input  logic [DATA_W-1:0] bad_addr_i,
    output logic [DATA_W-1:0] data_o,
    output logic [DATA_W-1:0] count_o,
    output logic [DATA_W-1:0] compare_o,
    output logic [DATA_W-1:0] status_o,
    output logic [DATA_W-1:0] cause_o,
    output logic [DATA_W-1:0] epc_o,
    output logic [DATA_W-1:0] ebase_o,
    output logic [DATA_W-1:0] badvaddr_o,
    output logic              timer_int_o
);

    // {register number, select}
    localparam logic [7:0] A_BADVADDR = {5'd8,  3'd0};
    localparam logic [7:0] A_COUNT    = {5'd9,  3'd0};
    localparam logic [7:0] A_COMPARE  = {5'd11, 3'd0};
    localparam logic [7:0] A_STATUS   = {5'd12, 3'd0};
    localparam logic [7:0] A_CAUSE    = {5'd13, 3'd0};
    localparam logic [7:0] A_EPC      = {5'd14, 3'd0};
    localparam logic [7:0] A_EBASE    = {5'd15, 3'd1};

    localparam logic [DATA_W-1:0] STATUS_WMASK = 32'h1040_FF17;
    localparam logic [DATA_W-1:0] STATUS_RST   = 32'h1000_0000;
    localparam logic [DATA_W-1:0] EBASE_RST    = 32'h8000_0000;
    localparam logic [DATA_W-1:0] EXC_ERET     = 32'h0000_000E;
    localparam int                EXL          = 1;

    // Only the masked Status bits take mtc0 data.
    function automatic logic [DATA_W-1:0] status_merge(input logic [DATA_W-1:0] cur,
                                                       input logic [DATA_W-1:0] wd);
        return (cur & ~STATUS_WMASK) | (wd & STATUS_WMASK);
    endfunction

    // Only the software interrupt bits IP[1:0] take mtc0 data.
    function automatic logic [DATA_W-1:0] cause_merge(input logic [DATA_W-1:0] cur,
                                                      input logic [DATA_W-1:0] wd);
        return {cur[31:10], wd[9:8], cur[7:0]};
    endfunction

    // EBase keeps its kseg0/kseg1 prefix and 4 KiB alignment.
    function automatic logic [DATA_W-1:0] ebase_merge(input logic [DATA_W-1:0] wd);
        return {2'b10, wd[29:12], 12'h000};
    endfunction

    // Internal exception encoding -> architectural ExcCode; unknown codes keep the old one.
    function automatic logic [4:0] exc_code(input logic [4:0] cur,
                                            input logic [DATA_W-1:0] et);
        case (et)
            32'h01:         return 5'd0;
            32'h08:         return 5'd8;
            32'h0a:         return 5'd10;
            32'h0c:         return 5'd12;
            32'h0f:         return 5'd9;
            32'h10, 32'h11: return 5'd4;
            32'h12:         return 5'd5;
            default:        return cur;
        endcase
    endfunction

    logic [7:0] wkey;
    logic [7:0] rkey;
    logic       wr_count, wr_compare, wr_status, wr_cause, wr_epc, wr_badvaddr, wr_ebase;
    logic       is_exc, is_eret, is_bad_addr;

    assign wkey = {waddr_i, wsel_i};
    assign rkey = {raddr_i, rsel_i};

    assign wr_count    = we_i && (wkey == A_COUNT);
    assign wr_compare  = we_i && (wkey == A_COMPARE);
    assign wr_status   = we_i && (wkey == A_STATUS);
    assign wr_cause    = we_i && (wkey == A_CAUSE);
    assign wr_epc      = we_i && (wkey == A_EPC);
    assign wr_badvaddr = we_i && (wkey == A_BADVADDR);
    assign wr_ebase    = we_i && (wkey == A_EBASE);

    assign is_eret     = (excepttype_i == EXC_ERET);
    assign is_exc      = (excepttype_i != '0) && !is_eret;
    assign is_bad_addr = (excepttype_i == 32'h10) || (excepttype_i == 32'h11) ||
                         (excepttype_i == 32'h12);

    logic [DATA_W-1:0] status_nx, cause_nx, epc_nx, badvaddr_nx;

    // mtc0 first, then exception/eret overrides the fields it owns.
    always_comb begin
        status_nx = wr_status ? status_merge(status_o, data_i) : status_o;
        if (is_exc)
            status_nx[EXL] = 1'b1;
        else if (is_eret)
            status_nx[EXL] = 1'b0;

        cause_nx        = wr_cause ? cause_merge(cause_o, data_i) : cause_o;
        cause_nx[15:10] = int_i;
        if (is_exc) begin
            cause_nx[6:2] = exc_code(cause_o[6:2], excepttype_i);
            // A nested exception must not lose the original return point.
            if (!status_o[EXL])
                cause_nx[31] = is_in_delayslot_i;
        end

        epc_nx = wr_epc ? data_i : epc_o;
        if (is_exc && !status_o[EXL])
            epc_nx = is_in_delayslot_i ? current_inst_addr_i - 32'd4 : current_inst_addr_i;

        badvaddr_nx = wr_badvaddr ? data_i : badvaddr_o;
        if (is_bad_addr)
            badvaddr_nx = bad_addr_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_o     <= '0;
            compare_o   <= '0;
            status_o    <= STATUS_RST;
            cause_o     <= '0;
            epc_o       <= '0;
            badvaddr_o  <= '0;
            ebase_o     <= EBASE_RST;
            timer_int_o <= 1'b0;
        end else begin
            count_o <= wr_count ? data_i : count_o + 32'd1;
            if (wr_compare)
                compare_o <= data_i;
            // Writing Compare acknowledges the timer interrupt.
            if (wr_compare)
                timer_int_o <= 1'b0;
            else if ((compare_o != '0) && (count_o == compare_o))
                timer_int_o <= 1'b1;
            status_o   <= status_nx;
            cause_o    <= cause_nx;
            epc_o      <= epc_nx;
            badvaddr_o <= badvaddr_nx;
            if (wr_ebase)
                ebase_o <= ebase_merge(data_i);
        end
    end

    logic [DATA_W-1:0] rd_val, wr_val;

    // A same-cycle mtc0 to the read address is forwarded as the value it will store.
    always_comb begin
        rd_val = '0;
        case (rkey)
            A_BADVADDR: rd_val = badvaddr_o;
            A_COUNT:    rd_val = count_o;
            A_COMPARE:  rd_val = compare_o;
            A_STATUS:   rd_val = status_o;
            A_CAUSE:    rd_val = cause_o;
            A_EPC:      rd_val = epc_o;
            A_EBASE:    rd_val = ebase_o;
            default:    rd_val = '0;
        endcase

        wr_val = '0;
        case (wkey)
            A_BADVADDR: wr_val = data_i;
            A_COUNT:    wr_val = data_i;
            A_COMPARE:  wr_val = data_i;
            A_STATUS:   wr_val = status_merge(status_o, data_i);
            A_CAUSE:    wr_val = cause_merge(cause_o, data_i);
            A_EPC:      wr_val = data_i;
            A_EBASE:    wr_val = ebase_merge(data_i);
            default:    wr_val = '0;
        endcase

        data_o = (we_i && (wkey == rkey)) ? wr_val : rd_val;
    end

endmodule

// File: doc/cp0_reg.md
CP0_REG -- requirements
Module: cp0_reg

Interface
REQ-001 SHALL expose: clk  in  1  system clock; rising edge.
REQ-002 SHALL expose: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL expose: we_i  in  1  mtc0 write enable (write-back stage).
REQ-004 SHALL expose: waddr_i  in  5, wsel_i  in  3, data_i  in  32  mtc0 register number, select and data.
REQ-005 SHALL expose: raddr_i  in  5, rsel_i  in  3  mfc0 read register number and select.
REQ-006 SHALL expose: int_i  in  6  external hardware interrupt lines, level-sensitive.
REQ-007 SHALL expose: excepttype_i  in  32, current_inst_addr_i  in  32, is_in_delayslot_i  in  1, bad_addr_i  in  32  committed exception information from the memory stage.
REQ-008 SHALL expose: data_o  out  32  mfc0 read data (combinational).
REQ-009 SHALL expose: count_o, compare_o, status_o, cause_o, epc_o, ebase_o, badvaddr_o  out  32 each  register contents.
REQ-010 SHALL expose: timer_int_o  out  1  timer interrupt request.
REQ-011 SHALL use reg addresses: BadVAddr 8, Count 9, Compare 11, Status 12, Cause 13, EPC 14, EBase 15 sel 1; all other reg/sel combinations read 0 and ignore writes.

Function
REQ-012 SHALL drive on reset: Count 0, Compare 0, Status 0x10000000, Cause 0, EPC 0, BadVAddr 0, EBase 0x80000000, timer_int_o 0.
REQ-013 SHALL increment Count by 1 every non-reset cycle, wrapping 0xFFFFFFFF -> 0; an mtc0 to Count that cycle loads data_i instead of incrementing.
REQ-014 SHALL set timer_int_o to 1 on the edge after a cycle where Compare != 0 and Count == Compare; it stays 1 until an mtc0 to Compare, which clears it on that same edge.
REQ-015 SHALL sample int_i into Cause[15:10] every cycle; Cause[9:8] (software interrupts) writable by mtc0; all other Cause bits not writable by mtc0.
REQ-016 SHALL apply mtc0 to Status through writable mask 0x1040FF17 (CU0, BEV, IM, UM, ERL, EXL, IE); unmasked bits keep their value.
REQ-017 SHALL make EPC and BadVAddr fully writable by mtc0; EBase writes affect bits [29:12] only, [31:30] fixed 2'b10, [11:0] fixed 0.
REQ-018 SHALL treat excepttype_i == 0 as no exception.
REQ-019 SHALL, for any non-zero excepttype_i other than 0x0e, with Status.EXL == 0: set EPC = current_inst_addr_i - 4 and Cause[31] (BD) = 1 if is_in_delayslot_i, else EPC = current_inst_addr_i and BD = 0.
REQ-020 SHALL, for exceptions with Status.EXL == 1 already, leave EPC and BD unchanged and update only ExcCode.
REQ-021 SHALL set Status.EXL = 1 and Cause[6:2] (ExcCode) per map: 0x01->0, 0x08->8, 0x0a->10, 0x0c->12, 0x0f->9, 0x10->4, 0x11->4, 0x12->5; any other code leaves ExcCode unchanged but still sets EXL.
REQ-022 SHALL load BadVAddr = bad_addr_i for codes 0x10, 0x11, 0x12.
REQ-023 SHALL, for excepttype_i == 0x0e (eret), clear Status.EXL only.
REQ-024 SHALL give exception/eret update priority over an mtc0 to the same field in the same cycle; mtc0 to unaffected fields still takes effect.
REQ-025 SHALL forward on read: if we_i and {waddr_i, wsel_i} == {raddr_i, rsel_i}, data_o returns the post-mask value being written; otherwise the register contents.
REQ-026 SHALL make all register outputs reflect updates one cycle after the causing edge, with no extra pipeline delay.

Reset
REQ-027 SHALL give rst priority over all events; reset mid-exception or during mtc0 discards the update and loads the REQ-012 values on that edge.
REQ-028 SHALL hold Count at 0 while rst is asserted; counting resumes on the first cycle after release.

Verification
REQ-029 SHALL verify: mtc0 Compare=5 after reset -> timer_int_o rises once Count reaches 5; mtc0 Compare=100 -> timer_int_o falls the next cycle.
REQ-030 SHALL verify: excepttype 0x08, addr 0xBFC00100, delayslot 0 -> EPC 0xBFC00100, ExcCode 8, EXL 1, BD 0.
REQ-031 SHALL verify: excepttype 0x0c, addr 0xBFC00200, delayslot 1 -> EPC 0xBFC001FC, BD 1; a second exception with EXL=1 leaves EPC at 0xBFC001FC.
REQ-032 SHALL verify: excepttype 0x11, bad_addr 0x80000003 -> BadVAddr 0x80000003, ExcCode 4; then 0x0e -> EXL 0, EPC unchanged.
REQ-033 SHALL verify: mtc0 Status=0xFFFFFFFF with simultaneous excepttype 0x01 -> Status 0x1040FF17 with EXL 1; same-cycle mfc0 Status returns 0x1040FF17.
REQ-034 SHALL verify: mtc0 EBase=0xFFFFFFFF -> ebase_o 0xBFFFF000; rst mid-sequence -> all outputs return to reset values.
